acc_result_gen: RTL

Upstream source of the acceleration-event interface. It converts a filtered sample stream into a debounced, hysteretic acceleration result level (filter_acc_result_o) and a programmable unit-time tick (filter_unit_flag_o). Both outputs drive the downstream acceleration delay/hold controller, which times its delay and hold windows in units of that tick. It also reports event statistics to the register bank.

---
 rtl/acc_result_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/acc_result_gen.sv
`default_nettype none
// ============================================================================
// Module   : acc_result_gen
// Brief    : Debounced, hysteretic acceleration-event level plus unit tick.
// Revision : 1.0
// ============================================================================
module acc_result_gen #(
  parameter real TCQ    = 0.1,
  parameter int  DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_data_i,
  input  logic [DATA_W-1:0] acc_thr_high_i,
  input  logic [DATA_W-1:0] acc_thr_low_i,
  input  logic [7:0]        acc_confirm_i,
  input  logic [15:0]       unit_period_i,
  output logic              filter_unit_flag_o,
  output logic              filter_acc_result_o,
  output logic [DATA_W-1:0] acc_peak_o,
  output logic [15:0]       acc_event_cnt_o
);

  // TCQ only matters to simulation models; it is never applied here.
  generate
    if (TCQ < 0.0) begin : g_tcq_unused
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_FALL_CHK = 2'd3
  } state_t;

  state_t            r_state;
  logic [7:0]        r_confirm_cnt;
  logic [15:0]       r_unit_cnt;
  logic              r_unit_flag;
  logic              r_acc_result;
  logic [DATA_W-1:0] r_peak;
  logic [15:0]       r_event_cnt;

  logic [15:0] w_eff_period;
  logic [7:0]  w_eff_confirm;
  logic [8:0]  w_cnt_inc;
  logic        w_confirm_done;
  logic        w_period_last;
  logic        w_is_high;
  logic        w_is_low;
  logic        w_peak_upd;
  logic [15:0] w_event_cnt_next;

  assign w_eff_period     = (unit_period_i == 16'd0) ? 16'd1 : unit_period_i;
  assign w_eff_confirm    = (acc_confirm_i == 8'd0) ? 8'd1 : acc_confirm_i;
  assign w_cnt_inc        = {1'b0, r_confirm_cnt} + 9'd1;
  // >= rather than == so a confirm value lowered mid-check cannot strand the counter
  assign w_confirm_done   = (w_cnt_inc >= {1'b0, w_eff_confirm});
  assign w_period_last    = (r_unit_cnt >= (w_eff_period - 16'd1));
  assign w_is_high        = (sample_data_i >= acc_thr_high_i);
  assign w_is_low         = (sample_data_i <= acc_thr_low_i);
  assign w_peak_upd       = (sample_data_i > r_peak);
  assign w_event_cnt_next = (r_event_cnt == 16'hFFFF) ? r_event_cnt : r_event_cnt + 16'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state       <= ST_IDLE;
      r_confirm_cnt <= 8'd0;
      r_unit_cnt    <= 16'd0;
      r_unit_flag   <= 1'b0;
      r_acc_result  <= 1'b0;
      r_peak        <= '0;
      r_event_cnt   <= 16'd0;
    end else if (!enable_i) begin
      r_state       <= ST_IDLE;
      r_confirm_cnt <= 8'd0;
      r_unit_cnt    <= 16'd0;
      r_unit_flag   <= 1'b0;
      r_acc_result  <= 1'b0;
    end else begin
      if (w_period_last) begin
        r_unit_cnt  <= 16'd0;
        r_unit_flag <= 1'b1;
      end else begin
        r_unit_cnt  <= r_unit_cnt + 16'd1;
        r_unit_flag <= 1'b0;
      end

      if (sample_valid_i) begin
        case (r_state)
          ST_IDLE: begin
            if (w_is_high) begin
              if (w_eff_confirm == 8'd1) begin
                r_state       <= ST_ACTIVE;
                r_confirm_cnt <= 8'd0;
                r_acc_result  <= 1'b1;
                r_peak        <= sample_data_i;
                r_event_cnt   <= w_event_cnt_next;
              end else begin
                r_state       <= ST_RISE_CHK;
                r_confirm_cnt <= 8'd1;
              end
            end
          end
          ST_RISE_CHK: begin
            if (w_is_high) begin
              if (w_confirm_done) begin
                r_state       <= ST_ACTIVE;
                r_confirm_cnt <= 8'd0;
                r_acc_result  <= 1'b1;
                r_peak        <= sample_data_i;
                r_event_cnt   <= w_event_cnt_next;
              end else begin
                r_confirm_cnt <= w_cnt_inc[7:0];
              end
            end else begin
              r_state       <= ST_IDLE;
              r_confirm_cnt <= 8'd0;
            end
          end
          ST_ACTIVE: begin
            if (w_peak_upd) r_peak <= sample_data_i;
            if (w_is_low) begin
              if (w_eff_confirm == 8'd1) begin
                r_state       <= ST_IDLE;
                r_confirm_cnt <= 8'd0;
                r_acc_result  <= 1'b0;
              end else begin
                r_state       <= ST_FALL_CHK;
                r_confirm_cnt <= 8'd1;
              end
            end
          end
          ST_FALL_CHK: begin
            if (w_peak_upd) r_peak <= sample_data_i;
            if (w_is_low) begin
              if (w_confirm_done) begin
                r_state       <= ST_IDLE;
                r_confirm_cnt <= 8'd0;
                r_acc_result  <= 1'b0;
              end else begin
                r_confirm_cnt <= w_cnt_inc[7:0];
              end
            end else begin
              r_state       <= ST_ACTIVE;
              r_confirm_cnt <= 8'd0;
            end
          end
          default: begin
            r_state       <= ST_IDLE;
            r_confirm_cnt <= 8'd0;
            r_acc_result  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign filter_unit_flag_o  = r_unit_flag;
  assign filter_acc_result_o = r_acc_result;
  assign acc_peak_o          = r_peak;
  assign acc_event_cnt_o     = r_event_cnt;

endmodule
`default_nettype wire
